// File: rtl/pio_edge_in_if.sv
// Avalon-MM slave bus bundle for the edge-capturing input PIO.
// The master side drives address/strobes and the slave returns registered readdata.
interface pio_edge_in_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/pio_edge_in.sv
// Input PIO for push-buttons and switches.
// Each channel has a synchroniser and a debounce filter, followed by
// rising/falling edge capture with write-1-to-clear.
// irq is built only from registers, so it has no glitch path from in_port.
module pio_edge_in #(
    parameter int WIDTH           = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    pio_edge_in_if.slave     bus,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_RAW      = 3'd1;
    localparam logic [2:0] ADDR_MASK     = 3'd2;
    localparam logic [2:0] ADDR_CAPTURE  = 3'd3;
    localparam logic [2:0] ADDR_RISE_EN  = 3'd4;
    localparam logic [2:0] ADDR_FALL_EN  = 3'd5;
    localparam logic [2:0] ADDR_STATUS   = 3'd6;

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] stable_d;
    logic [CNT_W-1:0] cnt [WIDTH];

    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_capture;
    logic [WIDTH-1:0] rise_en;
    logic [WIDTH-1:0] fall_en;

    logic             write_en;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] w1c;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [31:0]      rd_mux;
    logic             unused_wdata;

    assign sync     = sync_q[SYNC_STAGES-1];
    assign write_en = bus.chipselect & ~bus.write_n;
    assign wdata    = bus.writedata[WIDTH-1:0];

    // Upper writedata bits have no register behind them.
    assign unused_wdata = ^bus.writedata;

    // Metastability chain per channel, in_port enters at stage 0.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= in_port;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    // Debounce: accept a new level only after DEBOUNCE_CYCLES consecutive
    // cycles of disagreement; any cycle of agreement restarts the count.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stable <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    stable[i] <= sync[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // Edge qualification against the enables in force this cycle.
    always_comb begin
        rise = stable & ~stable_d & rise_en;
        fall = ~stable & stable_d & fall_en;
        w1c  = '0;
        if (write_en && bus.address == ADDR_CAPTURE) begin
            w1c = wdata;
        end
    end

    // Delayed level, control registers and capture; a new edge beats a same-cycle clear.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stable_d     <= '0;
            irq_mask     <= '0;
            edge_capture <= '0;
            rise_en      <= '1;
            fall_en      <= '0;
        end else begin
            stable_d     <= stable;
            edge_capture <= (edge_capture & ~w1c) | rise | fall;
            if (write_en) begin
                case (bus.address)
                    ADDR_MASK:    irq_mask <= wdata;
                    ADDR_RISE_EN: rise_en  <= wdata;
                    ADDR_FALL_EN: fall_en  <= wdata;
                    default: ;
                endcase
            end
        end
    end

    // Read mux; unused upper bits read as zero.
    always_comb begin
        rd_mux = '0;
        case (bus.address)
            ADDR_DATA:    rd_mux = 32'(stable);
            ADDR_RAW:     rd_mux = 32'(sync);
            ADDR_MASK:    rd_mux = 32'(irq_mask);
            ADDR_CAPTURE: rd_mux = 32'(edge_capture);
            ADDR_RISE_EN: rd_mux = 32'(rise_en);
            ADDR_FALL_EN: rd_mux = 32'(fall_en);
            ADDR_STATUS:  rd_mux = 32'(edge_capture & irq_mask);
            default:      rd_mux = '0;
        endcase
    end

    // Registered read data, updated every cycle regardless of chipselect.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bus.readdata <= '0;
        end else begin
            bus.readdata <= rd_mux;
        end
    end

    assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_pio_edge_in.sv
// Directed bench for pio_edge_in (WIDTH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=16).
// Expected values are queued when stimulus is applied and popped when the
// DUT output is sampled, 1 time unit after the rising edge.
module tb_pio_edge_in;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] in_port;
    logic       irq;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] exp_q [$];
    string       tag_q [$];

    pio_edge_in_if bus ();

    pio_edge_in #(
        .WIDTH           (4),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (16)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .in_port (in_port),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_push(input logic [31:0] exp, input string tag);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
    endtask

    task automatic compare(input logic [31:0] obs);
        logic [31:0] exp;
        string       tag;
        exp = exp_q.pop_front();
        tag = tag_q.pop_front();
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [2:0] addr, input logic [31:0] data);
        bus.address    = addr;
        bus.writedata  = data;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        tick();
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic read_chk(input logic [2:0] addr, input logic [31:0] exp, input string tag);
        bus.address = addr;
        expect_push(exp, tag);
        tick();
        compare(bus.readdata);
    endtask

    task automatic irq_chk(input logic exp, input string tag);
        expect_push(32'(exp), tag);
        compare(32'(irq));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        logic [31:0] rst_vals [8];
        rst_vals = '{32'h0, 32'h0, 32'h0, 32'h0, 32'hF, 32'h0, 32'h0, 32'h0};

        bus.address    = 3'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = 32'h0;
        in_port        = 4'h0;
        reset_n        = 1'b0;

        // Reset
        idle(3);
        expect_push(32'h0, "rst_readdata");
        compare(bus.readdata);
        irq_chk(1'b0, "rst_irq");
        reset_n = 1'b1;
        for (int a = 0; a < 8; a++) begin
            read_chk(3'(a), rst_vals[a], $sformatf("rst_reg%0d", a));
        end
        irq_chk(1'b0, "rst_irq_after");

        // Rising capture with exact latency: in_port set before edge k, irq after k+18
        bus_write(3'd2, 32'h1);
        in_port[0] = 1'b1;
        for (int j = 0; j <= 18; j++) begin
            tick();
            irq_chk(j == 18, $sformatf("rise_lat_e%0d", j));
        end
        read_chk(3'd3, 32'h1, "rise_capture");
        read_chk(3'd0, 32'h1, "rise_data");

        // Glitch rejection: 10 and 15 cycle pulses dropped, 16 accepted
        bus_write(3'd3, 32'hF);
        irq_chk(1'b0, "w1c_irq_clear");
        in_port[1] = 1'b1;
        idle(10);
        in_port[1] = 1'b0;
        idle(30);
        read_chk(3'd0, 32'h1, "glitch10_data");
        read_chk(3'd3, 32'h0, "glitch10_capture");
        in_port[1] = 1'b1;
        idle(15);
        in_port[1] = 1'b0;
        idle(30);
        read_chk(3'd3, 32'h0, "glitch15_capture");
        in_port[1] = 1'b1;
        idle(16);
        in_port[1] = 1'b0;
        idle(40);
        read_chk(3'd3, 32'h2, "pulse16_capture");
        read_chk(3'd0, 32'h1, "pulse16_data");
        irq_chk(1'b0, "pulse16_irq_masked");

        // Falling-only mode on bit 2
        bus_write(3'd3, 32'hF);
        bus_write(3'd4, 32'h0);
        bus_write(3'd5, 32'h4);
        bus_write(3'd2, 32'h0);
        in_port[2] = 1'b1;
        idle(20);
        read_chk(3'd0, 32'h5, "fall_data_high");
        read_chk(3'd3, 32'h0, "fall_no_rise");
        in_port[2] = 1'b0;
        idle(20);
        read_chk(3'd3, 32'h4, "fall_capture");
        read_chk(3'd4, 32'h0, "fall_rise_en");
        read_chk(3'd5, 32'h4, "fall_fall_en");
        bus_write(3'd2, 32'h4);
        irq_chk(1'b1, "fall_irq_mask4");
        read_chk(3'd6, 32'h4, "status_mask4");
        bus_write(3'd2, 32'h0);
        irq_chk(1'b0, "fall_irq_mask0");
        read_chk(3'd6, 32'h0, "status_mask0");
        bus_write(3'd4, 32'hF);
        bus_write(3'd5, 32'h0);
        read_chk(3'd3, 32'h4, "enables_keep_capture");

        // W1C collision: bits 0 and 3 captured, then same-edge set vs clear
        bus_write(3'd3, 32'hF);
        in_port[0] = 1'b0;
        idle(20);
        in_port = 4'b1001;
        idle(20);
        read_chk(3'd3, 32'h9, "coll_capture_09");
        bus_write(3'd2, 32'h8);
        irq_chk(1'b1, "coll_irq_mask8");
        bus_write(3'd3, 32'h1);
        read_chk(3'd3, 32'h8, "coll_w1c_bit0");
        in_port[3] = 1'b0;
        idle(20);
        irq_chk(1'b1, "coll_irq_hold");
        in_port[3] = 1'b1;
        for (int j = 0; j < 18; j++) begin
            tick();
            irq_chk(1'b1, $sformatf("coll_wait_e%0d", j));
        end
        bus_write(3'd3, 32'h8);
        irq_chk(1'b1, "coll_irq_set_wins");
        read_chk(3'd3, 32'h8, "coll_capture_set_wins");
        bus_write(3'd3, 32'h8);
        irq_chk(1'b0, "coll_irq_cleared");
        read_chk(3'd3, 32'h0, "coll_capture_cleared");

        // Reset mid-debounce: count discarded, capture 19 edges after last reset edge
        in_port = 4'h0;
        reset_n = 1'b0;
        idle(2);
        reset_n = 1'b1;
        in_port[0] = 1'b1;
        idle(12);
        reset_n = 1'b0;
        idle(2);
        expect_push(32'h0, "midrst_readdata");
        compare(bus.readdata);
        irq_chk(1'b0, "midrst_irq");
        reset_n = 1'b1;
        bus_write(3'd2, 32'h1);
        irq_chk(1'b0, "midrst_e1");
        for (int j = 2; j <= 19; j++) begin
            tick();
            irq_chk(j == 19, $sformatf("midrst_e%0d", j));
        end
        read_chk(3'd3, 32'h1, "midrst_capture");
        read_chk(3'd7, 32'h0, "reg7_zero");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
